// File: rtl/reg_file.sv
// reg_file: two-read, one-write register file with register 0 hardwired to zero.
//
// Parameters:
//   WIDTH  data width of each register
//   ADDR   address width; 2**ADDR registers
//
// Ports:
//   clk    rising-edge clock for writes
//   reset  asynchronous, active-high; clears every register
//   rd1    read data, port 1 (register rn1), combinational
//   rd2    read data, port 2 (register rn2), combinational
//   rn1    read address, port 1
//   rn2    read address, port 2
//   wn     write address (writes to 0 are discarded)
//   wd     write data, stored at full width
//   w      write enable, active-high
//
// Optional feature: define REG_FILE_BYPASS_EN to forward wd to a read port in the
// same cycle when that port addresses the register being written.
module reg_file #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ADDR  = 5
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic [ADDR-1:0]  rn1,
   input  logic [ADDR-1:0]  rn2,
   input  logic [ADDR-1:0]  wn,
   input  logic [WIDTH-1:0] wd,
   input  logic             w
);

   localparam int unsigned DEPTH = 2 ** ADDR;

   logic [WIDTH-1:0] regs [DEPTH];

   // Per-register enable: an unknown w evaluates false in the if, so no entry
   // other than the addressed one can ever be disturbed. Entry 0 is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (w && (wn == ADDR'(i))) begin
               regs[i] <= wd;
            end
         end
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic fwd_ok;
   assign fwd_ok = !reset && w && (wn != '0);
`endif

   always_comb begin
      rd1 = '0;
      if (rn1 != '0) begin
         rd1 = regs[rn1];
      end
`ifdef REG_FILE_BYPASS_EN
      if (fwd_ok && (wn == rn1)) begin
         rd1 = wd;
      end
`endif
   end

   always_comb begin
      rd2 = '0;
      if (rn2 != '0) begin
         rd2 = regs[rn2];
      end
`ifdef REG_FILE_BYPASS_EN
      if (fwd_ok && (wn == rn2)) begin
         rd2 = wd;
      end
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (default WIDTH=32, ADDR=5).
// Expected values follow the REG_FILE_BYPASS_EN setting of the build.
module tb_reg_file;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ADDR  = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] rd1, rd2;
   logic [ADDR-1:0]  rn1, rn2, wn;
   logic [WIDTH-1:0] wd;
   logic             w;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   reg_file #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
      .clk   (clk),
      .reset (reset),
      .rd1   (rd1),
      .rd2   (rd2),
      .rn1   (rn1),
      .rn2   (rn2),
      .wn    (wn),
      .wd    (wd),
      .w     (w)
   );

   always #5 clk = ~clk;

   // Stimulus only: one committed write, inputs driven away from the edge.
   task automatic do_write(input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      w = 1'b1; wn = a; wd = d;
      @(posedge clk);
      #1;
      w = 1'b0;
   endtask

   task automatic test_reset;
      rn1 = 5'd5; rn2 = 5'd0;
      #1;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h want %h", rd1, 32'h0); end
      n_checks++;
      if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 got %h want %h", rd2, 32'h0); end
      do_write(5'd5, 32'hDEADBEEF);
      n_checks++;
      if (rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_r5 got %h want %h", rd1, 32'hDEADBEEF); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL async_reset_r5 got %h want %h", rd1, 32'h0); end
      #1 reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL post_reset_r5 got %h want %h", rd1, 32'h0); end
   endtask

   task automatic test_basic_write;
      do_write(5'd7, 32'h12345678);
      rn1 = 5'd7; rn2 = 5'd7;
      #1;
      n_checks++;
      if (rd1 !== 32'h12345678) begin n_fail++; $display("FAIL basic_rd1 got %h want %h", rd1, 32'h12345678); end
      n_checks++;
      if (rd2 !== 32'h12345678) begin n_fail++; $display("FAIL basic_rd2 got %h want %h", rd2, 32'h12345678); end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (rd1 !== 32'h12345678) begin n_fail++; $display("FAIL basic_hold got %h want %h", rd1, 32'h12345678); end
   endtask

   task automatic test_reg0;
      @(negedge clk);
      w = 1'b1; wn = 5'd0; wd = 32'hFFFFFFFF; rn1 = 5'd0; rn2 = 5'd7;
      #1;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reg0_during got %h want %h", rd1, 32'h0); end
      @(posedge clk); #1;
      w = 1'b0;
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reg0_after got %h want %h", rd1, 32'h0); end
      n_checks++;
      if (rd2 !== 32'h12345678) begin n_fail++; $display("FAIL reg0_r7_intact got %h want %h", rd2, 32'h12345678); end
   endtask

   task automatic test_enable_gating;
      do_write(5'd3, 32'h00000011);
      @(negedge clk);
      w = 1'b0; wn = 5'd3; wd = 32'h22; rn1 = 5'd3;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (rd1 !== 32'h00000011) begin n_fail++; $display("FAIL enable_gating got %h want %h", rd1, 32'h00000011); end
   endtask

   task automatic test_same_cycle;
      logic [WIDTH-1:0] exp_before;
      do_write(5'd9, 32'hA);
      exp_before = BYPASS ? 32'hB : 32'hA;
      @(negedge clk);
      w = 1'b1; wn = 5'd9; wd = 32'hB; rn1 = 5'd9; rn2 = 5'd8;
      #1;
      n_checks++;
      if (rd1 !== exp_before) begin n_fail++; $display("FAIL same_cycle_before got %h want %h", rd1, exp_before); end
      n_checks++;
      if (rd2 !== 32'h0) begin n_fail++; $display("FAIL same_cycle_other_port got %h want %h", rd2, 32'h0); end
      @(posedge clk); #1;
      w = 1'b0;
      n_checks++;
      if (rd1 !== 32'hB) begin n_fail++; $display("FAIL same_cycle_after got %h want %h", rd1, 32'hB); end
   endtask

   task automatic test_random;
      logic [WIDTH-1:0] shadow [2**ADDR];
      logic [WIDTH-1:0] e1, e2;
      // Start from a known all-zero state.
      @(negedge clk);
      reset = 1'b1; #2 reset = 1'b0;
      for (int i = 0; i < 2**ADDR; i++) shadow[i] = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         wd  = $urandom;
         wn  = ADDR'($urandom_range(0, 2**ADDR - 1));
         w   = 1'($urandom_range(0, 1));
         rn1 = (c % 4 == 0) ? 5'd0 : ADDR'($urandom_range(0, 2**ADDR - 1));
         rn2 = (c % 5 == 1) ? wn : ADDR'($urandom_range(0, 2**ADDR - 1));
         #1;
         e1 = (rn1 == 0) ? '0 : shadow[rn1];
         e2 = (rn2 == 0) ? '0 : shadow[rn2];
         if (BYPASS && w && wn != 0 && wn == rn1) e1 = wd;
         if (BYPASS && w && wn != 0 && wn == rn2) e2 = wd;
         n_checks++;
         if (rd1 !== e1) begin n_fail++; $display("FAIL rand_rd1 cyc %0d rn1 %0d got %h want %h", c, rn1, rd1, e1); end
         n_checks++;
         if (rd2 !== e2) begin n_fail++; $display("FAIL rand_rd2 cyc %0d rn2 %0d got %h want %h", c, rn2, rd2, e2); end
         @(posedge clk);
         if (w && wn != 0) shadow[wn] = wd;
      end
      @(negedge clk);
      w = 1'b0; rn1 = 5'd0;
      for (int i = 1; i < 2**ADDR; i += 7) begin
         rn2 = ADDR'(i);
         #1;
         n_checks++;
         if (rd2 !== shadow[i]) begin n_fail++; $display("FAIL rand_final r%0d got %h want %h", i, rd2, shadow[i]); end
      end
      n_checks++;
      if (rd1 !== 32'h0) begin n_fail++; $display("FAIL rand_r0 got %h want %h", rd1, 32'h0); end
   endtask

   initial begin
      reset = 1'b1; w = 1'b0; wn = '0; wd = '0; rn1 = '0; rn2 = '0;
      #12 reset = 1'b0;
      test_reset;
      test_basic_write;
      test_reg0;
      test_enable_gating;
      test_same_cycle;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
